lcd_cmd_receiver: RTL and testbench
===================================

# lcd_cmd_receiver

Character-LCD responder that sits on the far end of the 10-bit `lcd_code` / `lcd_en` bus driven by the team's LCD controller. It behaves as an HD44780-style display: it captures each transfer on the falling edge of `lcd_en`, decodes the instruction or data byte, and maintains the display RAM, cursor address, display flags and busy timing. It serves as an on-chip display model for self-test and as the checker target in controller benches.

## Interface
- `DEPTH`, default 32: DDRAM characters. Must be a power of two.
- `AW`, default 5: address width, equal to log2(`DEPTH`).
- `BUSY_CYC`, default 40: busy cycles after any non-clear instruction or data write.
- `clk`  in  1: single clock. All logic is on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `lcd_code`  in  10: bit [9] is RS, bit [8] is RW, bits [7:0] are D.
- `lcd_en`  in  1: transfer strobe. It is asynchronous to `clk`, and the transfer commits on its falling edge.
- `lcd_on`  in  1: panel power. While 0, transfers are ignored.
- `rd_addr`  in  AW: checker read address.
- `rd_char`  out  8: DDRAM[`rd_addr`], registered with 1-cycle latency.
- `status_q`  out  8: {busy, 0, cursor_addr} zero-extended, captured on a busy-flag read.
- `busy`  out  1: instruction executing.
- `disp_on`, `cursor_on`, `blink_on`  out  1 each: display-control flags.
- `cursor_addr`  out  AW: current DDRAM address.
- `err_busy`  out  1: sticky flag. Set when a write transfer arrives while busy. Cleared only by reset.
- `xfer_cnt`  out  16: accepted transfers, saturating at 16'hFFFF.

## Operation
- **Edge detection.** `lcd_en` passes through a 2-FF synchronizer. The registered delayed copy gives `fall = sync_q & ~sync`.
- **Sampling.** `lcd_code` is sampled on the `fall` cycle. `lcd_code` must be stable from the rising edge of `lcd_en` until 3 `clk` after its falling edge.
- **FSM states** are IDLE, EXEC and CLEAR. `busy` = (state != IDLE).
- **IDLE, on `fall` with `lcd_on` = 1**, decode as follows:
  - RS=0, RW=1: busy-flag read. Set `status_q` = {busy, 0, cursor_addr}. Count the transfer. The state is unchanged.
  - RS=1, RW=0: data write. DDRAM[cursor_addr] <= D. Cursor moves by ±1 per I/D, modulo `DEPTH`. Go to EXEC.
  - RS=1, RW=1: data read. No effect other than `xfer_cnt`.
  - RS=0, RW=0, D=0x01: clear. Go to CLEAR with sweep pointer 0.
  - D in 0x02–0x03: home. `cursor_addr` <= 0. Go to EXEC.
  - D in 0x04–0x07: entry mode. I/D <= D[1]. D[0] (display shift) is ignored. Go to EXEC.
  - D in 0x08–0x0F: display control. `disp_on`, `cursor_on`, `blink_on` <= D[2], D[1], D[0]. Go to EXEC.
  - D in 0x10–0x1F: cursor shift. If D[3] = 0, the cursor moves by ±1 per D[2] (1 = right, +1). Go to EXEC.
  - D in 0x20–0x3F: function set. DL <= D[4], recorded internally only. Go to EXEC.
  - D in 0x40–0x7F: CGRAM address. Accepted, no state change. Go to EXEC.
  - D >= 0x80: `cursor_addr` <= D[AW-1:0]. Higher bits are dropped. Go to EXEC.
  - D = 0x00: no-op. Counted, state unchanged.
- **EXEC.** The counter loads `BUSY_CYC`-1 on entry and decrements each cycle. At 0 the FSM returns to IDLE.
- **CLEAR.** Writes DDRAM[ptr] <= 0x20 once per cycle for ptr = 0..`DEPTH`-1. On the last write: `cursor_addr` <= 0, I/D <= 1, return to IDLE.
- **While busy:**
  - A `fall` with RW=0 is dropped and sets `err_busy`.
  - A busy-flag read (RS=0, RW=1) is still honoured and returns busy=1.
- **Counting.** `xfer_cnt` increments on every `fall` with `lcd_on` = 1 that is not dropped.
- **`lcd_on` = 0** ignores `fall` entirely. An EXEC or CLEAR already in progress continues.

## Timing
- **Reset values:**
  - FSM = IDLE, I/D = 1.
  - `busy`, `disp_on`, `cursor_on`, `blink_on`, `err_busy` = 0.
  - `cursor_addr` = 0, `status_q` = 0, `xfer_cnt` = 0, `rd_char` = 0.
  - DDRAM is not reset; its contents are undefined until a clear.
- **Transfer latency.** `fall` asserts 3 `clk` after the falling edge of `lcd_en`. The commit (DDRAM write, flags, `cursor_addr`) is visible on the next cycle. `busy` rises in that same cycle.
- **Busy durations:** EXEC lasts exactly `BUSY_CYC` cycles. CLEAR lasts exactly `DEPTH` cycles.
- **Minimum strobe.** `lcd_en` high time and low time must each be at least 3 `clk`. Shorter pulses may be missed; this is legal, not an error.
- **Cursor wrap.** Increment from `DEPTH`-1 gives 0. Decrement from 0 gives `DEPTH`-1.
- **Reset mid-CLEAR or mid-EXEC.** The operation aborts immediately. A partially cleared DDRAM retains its mixed content.
- **Read vs. write collision.** `rd_char` reading an address in the same cycle it is written returns the old value.

## Structure
- **`lcd_pkg`** holds the state enum, the opcode range constants (CLEAR, HOME, ENTRY, DISPCTL, SHIFT, FUNC, CGRAM, DDRAM), the field bit positions RS=9 and RW=8, and SPACE = 8'h20.
- **`lcd_sync_edge`** is the sub-module: 2-FF synchronizer plus falling-edge pulse, with async active-low `rst`.
- **DDRAM** is a plain register array, 1 write port and 1 registered read port.

## Test plan
- **Init and text.** Send 0x001, 0x030, 0x00E, 0x006, then data 0x250, 0x252, 0x241, 0x24E, 0x241, 0x241, each after `busy` falls. Expect DDRAM[0..5] = 50 52 41 4E 41 41, `cursor_addr` = 6, `disp_on` = 1, `cursor_on` = 1, `blink_on` = 0, `xfer_cnt` = 10.
- **Clear.** Send 0x001 after text. Expect `busy` high exactly 32 cycles, all `rd_char` = 0x20, `cursor_addr` = 0.
- **Write while busy.** Send 0x241 one strobe after a data write, within 40 cycles. Expect DDRAM unchanged, `err_busy` = 1, `xfer_cnt` not incremented. A following 0x100 gives `status_q` = 0x80 | addr.
- **Wrap.** Send 0x09F, then 0x258: DDRAM[31] = 0x58 and `cursor_addr` = 0. Then send 0x004, then 0x259: DDRAM[0] = 0x59 and `cursor_addr` = 31.
- **Reset mid-clear.** Assert `rst` 10 cycles into CLEAR. Expect every output at its reset value immediately, DDRAM[0..9] = 0x20, DDRAM[10..] unchanged.
- **Power off.** With `lcd_on` = 0, send 0x241. Expect no change and `xfer_cnt` unchanged.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD responder: FSM states, opcode ranges,
// bus field positions and the instruction decoder.
package lcd_pkg;

  localparam int RS_BIT = 9;
  localparam int RW_BIT = 8;

  localparam logic [7:0] SPACE = 8'h20;

  // Lower bound of each instruction range; a range ends where the next one starts.
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPCTL = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR
  } state_e;

  typedef enum logic [3:0] {
    CMD_NOP,
    CMD_CLEAR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISPCTL,
    CMD_SHIFT,
    CMD_FUNC,
    CMD_CGRAM,
    CMD_DDRAM
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic [7:0] d);
    if (d >= OP_DDRAM)        return CMD_DDRAM;
    else if (d >= OP_CGRAM)   return CMD_CGRAM;
    else if (d >= OP_FUNC)    return CMD_FUNC;
    else if (d >= OP_SHIFT)   return CMD_SHIFT;
    else if (d >= OP_DISPCTL) return CMD_DISPCTL;
    else if (d >= OP_ENTRY)   return CMD_ENTRY;
    else if (d >= OP_HOME)    return CMD_HOME;
    else if (d >= OP_CLEAR)   return CMD_CLEAR;
    else                      return CMD_NOP;
  endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Brings the asynchronous lcd_en strobe into the clk domain and emits a
// one-cycle pulse for each falling edge.
module lcd_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= en_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign fall_o = dly_q & ~sync_q;

endmodule

// File: rtl/lcd_cmd_receiver.sv
// HD44780-style display model: decodes transfers on the lcd_code/lcd_en bus and
// maintains DDRAM, cursor, display flags and busy timing.
module lcd_cmd_receiver
  import lcd_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int BUSY_CYC = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    lcd_code,
  input  logic          lcd_en,
  input  logic          lcd_on,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_char,
  output logic [7:0]    status_q,
  output logic          busy,
  output logic          disp_on,
  output logic          cursor_on,
  output logic          blink_on,
  output logic [AW-1:0] cursor_addr,
  output logic          err_busy,
  output logic [15:0]   xfer_cnt
);

  localparam int CW = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BUSY_CYC - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] cursor_q, cursor_d;
  logic          id_q, id_d;
  logic          disp_q, disp_d;
  logic          curon_q, curon_d;
  logic          blink_q, blink_d;
  logic          dl_unused_q, dl_unused_d;
  logic          err_q, err_d;
  logic [7:0]    stat_q, stat_d;
  logic [15:0]   xfer_q, xfer_d;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_q;

  logic          fall;
  logic          accept;
  logic          count_xfer;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  logic          rs;
  logic          rw;
  logic [7:0]    d;
  logic          busy_w;
  logic [7:0]    stat_word;
  logic [AW-1:0] cursor_step;
  logic [AW-1:0] cursor_inc;
  logic [AW-1:0] cursor_dec;

  lcd_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .en_i   (lcd_en),
    .fall_o (fall)
  );

  assign rs          = lcd_code[RS_BIT];
  assign rw          = lcd_code[RW_BIT];
  assign d           = lcd_code[7:0];
  assign accept      = fall & lcd_on;
  assign busy_w      = (state_q != ST_IDLE);
  assign stat_word   = {busy_w, 7'(cursor_q)};
  assign cursor_inc  = cursor_q + AW'(1);
  assign cursor_dec  = cursor_q - AW'(1);
  assign cursor_step = id_q ? cursor_inc : cursor_dec;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    cursor_d    = cursor_q;
    id_d        = id_q;
    disp_d      = disp_q;
    curon_d     = curon_q;
    blink_d     = blink_q;
    dl_unused_d = dl_unused_q;
    err_d       = err_q;
    stat_d      = stat_q;
    count_xfer  = 1'b0;
    we          = 1'b0;
    waddr       = cursor_q;
    wdata       = d;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          count_xfer = 1'b1;
          case ({rs, rw})
            2'b01: stat_d = stat_word;
            2'b10: begin
              we       = 1'b1;
              cursor_d = cursor_step;
              state_d  = ST_EXEC;
              cnt_d    = CNT_LOAD;
            end
            2'b00: begin
              state_d = ST_EXEC;
              cnt_d   = CNT_LOAD;
              case (decode_cmd(d))
                CMD_NOP:     state_d = ST_IDLE;
                CMD_CLEAR: begin
                  state_d = ST_CLEAR;
                  ptr_d   = '0;
                end
                CMD_HOME:    cursor_d = '0;
                CMD_ENTRY:   id_d = d[1];
                CMD_DISPCTL: begin
                  disp_d  = d[2];
                  curon_d = d[1];
                  blink_d = d[0];
                end
                CMD_SHIFT: begin
                  if (!d[3]) cursor_d = d[2] ? cursor_inc : cursor_dec;
                end
                CMD_FUNC:    dl_unused_d = d[4];
                CMD_DDRAM:   cursor_d = d[AW-1:0];
                default:     ;
              endcase
            end
            default: ;
          endcase
        end
      end

      ST_EXEC: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end

      ST_CLEAR: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = SPACE;
        if (ptr_q == PTR_LAST) begin
          state_d  = ST_IDLE;
          cursor_d = '0;
          id_d     = 1'b1;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // While busy only reads get through; any write is dropped and flagged.
    if (busy_w && accept) begin
      if (!rw) begin
        err_d = 1'b1;
      end else begin
        count_xfer = 1'b1;
        if (!rs) stat_d = stat_word;
      end
    end
  end

  assign xfer_d = (count_xfer && xfer_q != 16'hFFFF) ? xfer_q + 16'd1 : xfer_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      cursor_q    <= '0;
      id_q        <= 1'b1;
      disp_q      <= 1'b0;
      curon_q     <= 1'b0;
      blink_q     <= 1'b0;
      dl_unused_q <= 1'b0;
      err_q       <= 1'b0;
      stat_q      <= '0;
      xfer_q      <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      cursor_q    <= cursor_d;
      id_q        <= id_d;
      disp_q      <= disp_d;
      curon_q     <= curon_d;
      blink_q     <= blink_d;
      dl_unused_q <= dl_unused_d;
      err_q       <= err_d;
      stat_q      <= stat_d;
      xfer_q      <= xfer_d;
      rd_q        <= mem[rd_addr];
    end
  end

  // DDRAM keeps its contents across reset, so it has no reset branch.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_char     = rd_q;
  assign status_q    = stat_q;
  assign busy        = busy_w;
  assign disp_on     = disp_q;
  assign cursor_on   = curon_q;
  assign blink_on    = blink_q;
  assign cursor_addr = cursor_q;
  assign err_busy    = err_q;
  assign xfer_cnt    = xfer_q;

endmodule

// File: tb/tb_lcd_cmd_receiver.sv
// Self-checking bench for lcd_cmd_receiver: scenario tasks plus random traffic,
// all compared against a behavioural display model.
module tb_lcd_cmd_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  lcd_code = '0;
  logic        lcd_en = 1'b0;
  logic        lcd_on = 1'b1;
  logic [4:0]  rd_addr = '0;
  logic [7:0]  rd_char;
  logic [7:0]  status_q;
  logic        busy;
  logic        disp_on;
  logic        cursor_on;
  logic        blink_on;
  logic [4:0]  cursor_addr;
  logic        err_busy;
  logic [15:0] xfer_cnt;

  int asserts = 0;
  int fails   = 0;

  // Behavioural display model
  logic [7:0] mMem [32];
  bit         mValid [32];
  int         mCursor;
  bit         mId, mDisp, mCurOn, mBlink, mErr;
  int         mXfer;
  logic [7:0] mStatus;
  logic [7:0] dump [32];

  lcd_cmd_receiver #(.DEPTH(32), .AW(5), .BUSY_CYC(40)) dut (
    .clk         (clk),
    .rst         (rst),
    .lcd_code    (lcd_code),
    .lcd_en      (lcd_en),
    .lcd_on      (lcd_on),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .status_q    (status_q),
    .busy        (busy),
    .disp_on     (disp_on),
    .cursor_on   (cursor_on),
    .blink_on    (blink_on),
    .cursor_addr (cursor_addr),
    .err_busy    (err_busy),
    .xfer_cnt    (xfer_cnt)
  );

  always #5 clk = ~clk;

  logic [32:0] dutRegs;
  assign dutRegs = {cursor_addr, disp_on, cursor_on, blink_on, err_busy, xfer_cnt, status_q};

  function automatic logic [32:0] expRegs();
    return {5'(mCursor), mDisp, mCurOn, mBlink, mErr, 16'(mXfer), mStatus};
  endfunction

  task automatic modelReset();
    mCursor = 0; mId = 1; mDisp = 0; mCurOn = 0; mBlink = 0; mErr = 0;
    mXfer = 0; mStatus = 8'h00;
  endtask

  // Applies one transfer to the model; returns the busy length it should cause.
  task automatic modelXfer(input logic [9:0] code, input bit busyNow, output int busyCyc);
    logic [7:0] d;
    d = code[7:0];
    busyCyc = 0;
    if (!lcd_on) return;
    if (busyNow) begin
      if (!code[8]) begin
        mErr = 1;
        return;
      end
      if (!code[9]) mStatus = 8'h80 | 8'(mCursor);
      if (mXfer < 65535) mXfer++;
      return;
    end
    if (mXfer < 65535) mXfer++;
    if (code[8]) begin
      if (!code[9]) mStatus = 8'(mCursor);
      return;
    end
    if (code[9]) begin
      mMem[mCursor] = d;
      mValid[mCursor] = 1;
      mCursor = (mCursor + (mId ? 1 : 31)) % 32;
      busyCyc = 40;
      return;
    end
    if (d == 8'h00) return;
    if (d == 8'h01) begin
      for (int i = 0; i < 32; i++) begin
        mMem[i] = 8'h20;
        mValid[i] = 1;
      end
      mCursor = 0;
      mId = 1;
      busyCyc = 32;
      return;
    end
    if (d < 8'h04) mCursor = 0;
    else if (d < 8'h08) mId = d[1];
    else if (d < 8'h10) begin
      mDisp = d[2]; mCurOn = d[1]; mBlink = d[0];
    end else if (d < 8'h20) begin
      if (!d[3]) mCursor = (mCursor + (d[2] ? 1 : 31)) % 32;
    end else if (d >= 8'h80) mCursor = d % 32;
    busyCyc = 40;
  endtask

  // Full transfer from idle, counting how many cycles busy is held afterwards.
  task automatic sendXfer(input logic [9:0] code, input string name);
    int expBusy;
    int seen;
    modelXfer(code, 1'b0, expBusy);
    @(negedge clk);
    lcd_code = code;
    lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    lcd_en = 1'b0;
    seen = 0;
    repeat (expBusy + 20) begin
      @(negedge clk);
      if (busy) seen++;
    end
    asserts++;
    if (seen !== expBusy) begin
      fails++;
      $display("[TB] FAIL busy_len(%s): got %0d cycles expected %0d", name, seen, expBusy);
    end
  endtask

  task automatic strobeOnly(input logic [9:0] code, input bit busyNow);
    int unusedBusy;
    modelXfer(code, busyNow, unusedBusy);
    @(negedge clk);
    lcd_code = code;
    lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    lcd_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic waitIdle(input string name);
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    asserts++;
    if (busy) begin
      fails++;
      $display("[TB] FAIL idle_timeout(%s): busy still %0b expected 0", name, busy);
    end
  endtask

  task automatic readDdram();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_addr = 5'(i);
      @(negedge clk);
      dump[i] = rd_char;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    modelReset();
    asserts++;
    if (dutRegs !== expRegs() || busy !== 1'b0 || rd_char !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_state: got regs=%h busy=%b rd=%h expected regs=%h busy=0 rd=00",
               dutRegs, busy, rd_char, expRegs());
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_init_text();
    logic [9:0] seq [10];
    seq = '{10'h001, 10'h030, 10'h00E, 10'h006, 10'h250, 10'h252, 10'h241, 10'h24E, 10'h241, 10'h241};
    foreach (seq[i]) sendXfer(seq[i], "init_text");
    asserts++;
    if (dutRegs !== expRegs()) begin
      fails++;
      $display("[TB] FAIL init_regs: got %h expected %h", dutRegs, expRegs());
    end
    asserts++;
    if (cursor_addr !== 5'd6 || xfer_cnt !== 16'd10 || {disp_on, cursor_on, blink_on} !== 3'b110) begin
      fails++;
      $display("[TB] FAIL init_const: got cur=%0d cnt=%0d flags=%b expected cur=6 cnt=10 flags=110",
               cursor_addr, xfer_cnt, {disp_on, cursor_on, blink_on});
    end
    readDdram();
    for (int i = 0; i < 32; i++) begin
      if (mValid[i]) begin
        asserts++;
        if (dump[i] !== mMem[i]) begin
          fails++;
          $display("[TB] FAIL init_ddram[%0d]: got %h expected %h", i, dump[i], mMem[i]);
        end
      end
    end
  endtask

  task automatic test_clear();
    sendXfer(10'h001, "clear");
    asserts++;
    if (dutRegs !== expRegs() || cursor_addr !== 5'd0) begin
      fails++;
      $display("[TB] FAIL clear_regs: got %h expected %h", dutRegs, expRegs());
    end
    readDdram();
    for (int i = 0; i < 32; i++) begin
      asserts++;
      if (dump[i] !== 8'h20) begin
        fails++;
        $display("[TB] FAIL clear_ddram[%0d]: got %h expected 20", i, dump[i]);
      end
    end
  endtask

  task automatic test_write_busy();
    strobeOnly(10'h242, 1'b0);
    strobeOnly(10'h241, 1'b1);
    strobeOnly(10'h100, 1'b1);
    asserts++;
    if (status_q !== mStatus || err_busy !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL busy_status: got st=%h err=%b busy=%b expected st=%h err=1 busy=1",
               status_q, err_busy, busy, mStatus);
    end
    waitIdle("write_busy");
    asserts++;
    if (dutRegs !== expRegs()) begin
      fails++;
      $display("[TB] FAIL busy_regs: got %h expected %h", dutRegs, expRegs());
    end
    readDdram();
    for (int i = 0; i < 32; i++) begin
      asserts++;
      if (dump[i] !== mMem[i]) begin
        fails++;
        $display("[TB] FAIL busy_ddram[%0d]: got %h expected %h", i, dump[i], mMem[i]);
      end
    end
  endtask

  task automatic test_wrap();
    sendXfer(10'h09F, "wrap_set");
    sendXfer(10'h258, "wrap_up");
    asserts++;
    if (cursor_addr !== 5'd0 || dutRegs !== expRegs()) begin
      fails++;
      $display("[TB] FAIL wrap_up: got %h expected %h", dutRegs, expRegs());
    end
    sendXfer(10'h004, "wrap_entry");
    sendXfer(10'h259, "wrap_down");
    asserts++;
    if (cursor_addr !== 5'd31 || dutRegs !== expRegs()) begin
      fails++;
      $display("[TB] FAIL wrap_down: got %h expected %h", dutRegs, expRegs());
    end
    readDdram();
    asserts++;
    if (dump[31] !== 8'h58 || dump[0] !== 8'h59) begin
      fails++;
      $display("[TB] FAIL wrap_ddram: got [31]=%h [0]=%h expected 58 59", dump[31], dump[0]);
    end
  endtask

  task automatic test_power_off();
    lcd_on = 1'b0;
    sendXfer(10'h241, "power_off");
    asserts++;
    if (dutRegs !== expRegs()) begin
      fails++;
      $display("[TB] FAIL power_regs: got %h expected %h", dutRegs, expRegs());
    end
    readDdram();
    for (int i = 0; i < 32; i++) begin
      asserts++;
      if (dump[i] !== mMem[i]) begin
        fails++;
        $display("[TB] FAIL power_ddram[%0d]: got %h expected %h", i, dump[i], mMem[i]);
      end
    end
    lcd_on = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) sendXfer(10'($urandom), "random");
    asserts++;
    if (dutRegs !== expRegs()) begin
      fails++;
      $display("[TB] FAIL random_regs: got %h expected %h", dutRegs, expRegs());
    end
    readDdram();
    for (int i = 0; i < 32; i++) begin
      if (mValid[i]) begin
        asserts++;
        if (dump[i] !== mMem[i]) begin
          fails++;
          $display("[TB] FAIL random_ddram[%0d]: got %h expected %h", i, dump[i], mMem[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int k;
    sendXfer(10'h006, "fill_entry");
    for (int i = 0; i < 32; i++) sendXfer({2'b10, 8'($urandom_range(0, 255))}, "fill");
    @(negedge clk);
    lcd_code = 10'h001;
    lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    lcd_en = 1'b0;
    k = 0;
    while (!busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    asserts++;
    if (!busy) begin
      fails++;
      $display("[TB] FAIL clear_start: busy got %b expected 1", busy);
    end
    // Ten sweep writes land before reset is asserted.
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) mMem[i] = 8'h20;
    modelReset();
    #1;
    asserts++;
    if (dutRegs !== expRegs() || busy !== 1'b0 || rd_char !== 8'h00) begin
      fails++;
      $display("[TB] FAIL midclear_reset: got regs=%h busy=%b rd=%h expected regs=%h busy=0 rd=00",
               dutRegs, busy, rd_char, expRegs());
    end
    @(negedge clk);
    rst = 1'b1;
    readDdram();
    for (int i = 0; i < 32; i++) begin
      asserts++;
      if (dump[i] !== mMem[i]) begin
        fails++;
        $display("[TB] FAIL midclear_ddram[%0d]: got %h expected %h", i, dump[i], mMem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mMem[i] = 8'h00;
      mValid[i] = 0;
    end
    test_reset();
    test_init_text();
    test_clear();
    test_write_busy();
    test_wrap();
    test_power_off();
    test_random();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
